// File: rtl/mvu_pkg.sv
// mvu_pkg: shared types and default parameters for the MVU memory bridge.
// Response-pipeline entry type plus default geometry of the MVU RAM port.
package mvu_pkg;

    localparam int unsigned MVU_ADDR_W          = 32;
    localparam int unsigned MVU_DATA_W          = 32;
    localparam int unsigned MVU_RAM_DATA_W      = 64;
    localparam int unsigned MVU_RAM_ADDR_W      = 15;
    localparam logic [31:0] MVU_BASE_ADDR       = 32'h7000_0000;
    localparam int unsigned MVU_READ_LATENCY    = 2;
    localparam int unsigned MVU_MAX_OUTSTANDING = 4;

    // Lane field is sized for up to 256 host words per RAM word.
    localparam int unsigned MVU_LANE_W          = 8;

    typedef struct packed {
        logic                  valid;
        logic                  is_read;
        logic [MVU_LANE_W-1:0] lane;
        logic                  err;
    } mvu_bridge_rsp_t;

endpackage

// File: rtl/mvu_bridge_rsp_pipe.sv
// mvu_bridge_rsp_pipe: fixed-depth shift register of response descriptors.
// Aligns each granted request with RAM read data arriving Depth cycles later.
module mvu_bridge_rsp_pipe
    import mvu_pkg::*;
#(
    parameter int unsigned Depth = MVU_READ_LATENCY
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  mvu_bridge_rsp_t rsp_i,
    output mvu_bridge_rsp_t rsp_o
);

    mvu_bridge_rsp_t stage_q [Depth];

    // Advance one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= rsp_i;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/mvu_mem_bridge.sv
// mvu_mem_bridge: 32-bit host word requests onto the wide MVU RAM port.
// Optional MVU_MEM_BRIDGE_STATS_EN adds saturating read/write/stall counters.
module mvu_mem_bridge
    import mvu_pkg::*;
#(
    parameter int unsigned          AddrWidth      = MVU_ADDR_W,
    parameter int unsigned          DataWidth      = MVU_DATA_W,
    parameter int unsigned          RamDataWidth   = MVU_RAM_DATA_W,
    parameter int unsigned          RamAddrWidth   = MVU_RAM_ADDR_W,
    parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(MVU_BASE_ADDR),
    parameter int unsigned          ReadLatency    = MVU_READ_LATENCY,
    parameter int unsigned          MaxOutstanding = MVU_MAX_OUTSTANDING
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mem_req_i,
    output logic                      mem_gnt_o,
    input  logic                      mem_we_i,
    input  logic [AddrWidth-1:0]      mem_addr_i,
    input  logic [DataWidth/8-1:0]    mem_strb_i,
    input  logic [DataWidth-1:0]      mem_wdata_i,
    output logic [DataWidth-1:0]      mem_rdata_o,
    output logic                      mem_rvalid_o,
    output logic                      mem_err_o,
    input  logic                      mvu_busy_i,
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [RamAddrWidth-1:0]   ram_addr_o,
    output logic [RamDataWidth/8-1:0] ram_be_o,
    output logic [RamDataWidth-1:0]   ram_wdata_o,
    input  logic [RamDataWidth-1:0]   ram_rdata_i
`ifdef MVU_MEM_BRIDGE_STATS_EN
   ,output logic [31:0]               stat_rd_o,
    output logic [31:0]               stat_wr_o,
    output logic [31:0]               stat_stall_o
`endif
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned Lanes = RamDataWidth / DataWidth;
    localparam int unsigned OB    = $clog2(StrbW);
    localparam int unsigned LB    = $clog2(RamDataWidth / 8);
    localparam int unsigned HiBit = RamAddrWidth + LB;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic [AddrWidth-1:0]  off;
    logic                  in_range;
    logic [MVU_LANE_W-1:0] lane;
    logic [CntW-1:0]       cnt_q, cnt_d;
    mvu_bridge_rsp_t       rsp_in, rsp_out;

    assign off      = mem_addr_i - BaseAddr;
    assign in_range = (off >> HiBit) == '0;
    assign lane     = MVU_LANE_W'((off >> OB) % Lanes);

    assign mem_gnt_o = mem_req_i & ~mvu_busy_i
                     & (cnt_q < CntW'(MaxOutstanding));
    assign ram_req_o = mem_gnt_o & in_range;
    assign ram_we_o  = ram_req_o & mem_we_i;

    // RAM-side fields stay quiet unless an access is actually issued.
    assign ram_addr_o  = ram_req_o ? off[HiBit-1:LB] : '0;
    assign ram_wdata_o = ram_we_o ? {Lanes{mem_wdata_i}} : '0;

    // Strobes land in the addressed lane for writes; reads fetch the whole word.
    always_comb begin
        ram_be_o = '0;
        if (ram_req_o) begin
            for (int unsigned i = 0; i < Lanes; i++) begin
                if (!mem_we_i)
                    ram_be_o[i*StrbW +: StrbW] = '1;
                else if (MVU_LANE_W'(i) == lane)
                    ram_be_o[i*StrbW +: StrbW] = mem_strb_i;
            end
        end
    end

    // Descriptor for every granted request, reads, writes and errors alike.
    always_comb begin
        rsp_in         = '0;
        rsp_in.valid   = mem_gnt_o;
        rsp_in.is_read = mem_gnt_o & ~mem_we_i;
        rsp_in.lane    = lane;
        rsp_in.err     = mem_gnt_o & ~in_range;
    end

    mvu_bridge_rsp_pipe #(
        .Depth (ReadLatency)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rsp_i  (rsp_in),
        .rsp_o  (rsp_out)
    );

    assign mem_rvalid_o = rsp_out.valid;
    assign mem_err_o    = rsp_out.valid & rsp_out.err;
    assign mem_rdata_o  = (rsp_out.valid & rsp_out.is_read & ~rsp_out.err)
                        ? ram_rdata_i[rsp_out.lane*DataWidth +: DataWidth]
                        : '0;

    // Outstanding count: grants in, responses out; both together cancel.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({mem_gnt_o, mem_rvalid_o})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

`ifdef MVU_MEM_BRIDGE_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

    // Saturating event counters for granted reads/writes and stalled cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_rd_q    <= '0;
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (mem_gnt_o && !mem_we_i && stat_rd_q != '1)
                stat_rd_q <= stat_rd_q + 32'd1;
            if (mem_gnt_o && mem_we_i && stat_wr_q != '1)
                stat_wr_q <= stat_wr_q + 32'd1;
            if (mem_req_i && !mem_gnt_o && stat_stall_q != '1)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_rd_o    = stat_rd_q;
    assign stat_wr_o    = stat_wr_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_mvu_mem_bridge.sv
// tb_mvu_mem_bridge: scoreboard bench with a byte-level host memory model.
// A second instance (ReadLatency 4, MaxOutstanding 4) exercises the request limit.
`timescale 1ns/1ps
module tb_mvu_mem_bridge;

    localparam int          L    = 2;
    localparam logic [31:0] BASE = 32'h7000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mem_req, mem_we, mvu_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic        ram_req, ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata, ram_rdata, ram_p1;

    logic        l_req, l_gnt, l_rvalid, l_err, l_ram_req, l_ram_we;
    logic [31:0] l_rdata;
    logic [14:0] l_ram_addr;
    logic [7:0]  l_ram_be;
    logic [63:0] l_ram_wdata;

`ifdef MVU_MEM_BRIDGE_STATS_EN
    logic [31:0] s_rd, s_wr, s_st, ls_rd, ls_wr, ls_st;
`endif

    mvu_mem_bridge u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (mem_gnt),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_strb_i   (mem_strb),
        .mem_wdata_i  (mem_wdata),
        .mem_rdata_o  (mem_rdata),
        .mem_rvalid_o (mem_rvalid),
        .mem_err_o    (mem_err),
        .mvu_busy_i   (mvu_busy),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_be_o     (ram_be),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
`ifdef MVU_MEM_BRIDGE_STATS_EN
       ,.stat_rd_o    (s_rd),
        .stat_wr_o    (s_wr),
        .stat_stall_o (s_st)
`endif
    );

    mvu_mem_bridge #(
        .ReadLatency    (4),
        .MaxOutstanding (4)
    ) u_lim (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_req_i    (l_req),
        .mem_gnt_o    (l_gnt),
        .mem_we_i     (1'b0),
        .mem_addr_i   (BASE),
        .mem_strb_i   (4'hF),
        .mem_wdata_i  (32'h0),
        .mem_rdata_o  (l_rdata),
        .mem_rvalid_o (l_rvalid),
        .mem_err_o    (l_err),
        .mvu_busy_i   (1'b0),
        .ram_req_o    (l_ram_req),
        .ram_we_o     (l_ram_we),
        .ram_addr_o   (l_ram_addr),
        .ram_be_o     (l_ram_be),
        .ram_wdata_o  (l_ram_wdata),
        .ram_rdata_i  (64'h1111_2222_3333_4444)
`ifdef MVU_MEM_BRIDGE_STATS_EN
       ,.stat_rd_o    (ls_rd),
        .stat_wr_o    (ls_wr),
        .stat_stall_o (ls_st)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0]  refm [int unsigned];
    logic [63:0] ram_mem [int unsigned];

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM behind the main DUT: 2-cycle read latency, junk otherwise.
    always @(posedge clk) begin
        logic [63:0] w;
        if (ram_req && ram_we) begin
            w = ram_mem.exists(32'(ram_addr)) ? ram_mem[32'(ram_addr)] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (ram_be[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
            ram_mem[32'(ram_addr)] = w;
        end
        if (ram_req && !ram_we)
            ram_p1 <= ram_mem.exists(32'(ram_addr)) ? ram_mem[32'(ram_addr)] : 64'h0;
        else
            ram_p1 <= {$urandom, $urandom};
        ram_rdata <= ram_p1;
    end

    // Monitor: every cycle either the queue head is due or rvalid must be low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("rsp", {mem_rvalid, mem_err, mem_rdata},
                      {1'b1, mon_e.err, mon_e.data});
            end else begin
                check("idle_rvalid", mem_rvalid, 1'b0);
            end
        end
    end

    task automatic idle(input int n, input bit rand_busy);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            mem_req  = 1'b0;
            mvu_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("idle_ram_req", ram_req, 1'b0);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata,
                         input int busy_cyc);
        logic [31:0] off, expd;
        logic [7:0]  be;
        logic        inr;
        int unsigned key;
        off = addr - BASE;
        inr = off < 32'h0004_0000;
        for (int k = 0; k <= busy_cyc; k++) begin
            @(posedge clk); #1;
            mem_req   = 1'b1;
            mem_we    = we;
            mem_addr  = addr;
            mem_strb  = strb;
            mem_wdata = wdata;
            mvu_busy  = (k < busy_cyc);
            @(negedge clk);
            check("gnt", mem_gnt, !mvu_busy);
            if (mvu_busy) begin
                check("busy_ram_req", ram_req, 1'b0);
            end else begin
                be = we ? (off[2] ? {strb, 4'h0} : {4'h0, strb}) : 8'hFF;
                if (inr)
                    check("ram_port",
                          {ram_req, ram_we, ram_addr, ram_be,
                           we ? ram_wdata : 64'h0},
                          {1'b1, we, off[17:3], be,
                           we ? {wdata, wdata} : 64'h0});
                else
                    check("ram_oor", ram_req, 1'b0);
                expd = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    key = {off[31:2], 2'b00} + 32'(b);
                    if (inr && we && strb[b]) refm[key] = wdata[8*b +: 8];
                    if (inr && !we)
                        expd[8*b +: 8] = refm.exists(key) ? refm[key] : 8'h00;
                end
                sb.push_back('{cyc + L, expd, !inr});
            end
        end
    endtask

    task automatic check_reset_state(input string nm);
        check(nm, {mem_gnt, mem_rvalid, mem_err, ram_req, ram_we,
                   mem_rdata, ram_addr, ram_be, ram_wdata}, '0);
    endtask

    task automatic lim_test();
        int   g[$];
        int   cnt;
        logic expg, expv;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            l_req = (g.size() < 6);
            @(negedge clk);
            cnt  = 0;
            expv = 1'b0;
            foreach (g[i]) begin
                if (g[i] < c && g[i] >= c - 4) cnt++;
                if (g[i] + 4 == c) expv = 1'b1;
            end
            expg = l_req && (cnt < 4);
            check("lim_gnt", l_gnt, expg);
            check("lim_rsp", {l_rvalid, l_err, l_rdata},
                  {expv, 1'b0, expv ? 32'h3333_4444 : 32'h0});
            if (expg) g.push_back(c);
        end
        l_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_strb = 0;
        mem_wdata = 0; mvu_busy = 0; l_req = 0;
        ram_p1 = 0; ram_rdata = 0;

        repeat (3) @(negedge clk);
        check_reset_state("reset_out");
        rst_n = 1'b1;
        idle(2, 0);

        issue(1'b1, 32'h7000_0004, 4'hF, 32'hCAFE_F00D, 0);
        issue(1'b0, 32'h7000_0004, 4'h0, 32'h0, 0);
        idle(4, 0);

        for (int i = 0; i < 8; i++)
            issue(1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, 0);
        idle(4, 0);

        issue(1'b0, 32'h7000_0004, 4'h0, 32'h0, 5);
        idle(4, 0);

        issue(1'b0, 32'h7004_0000, 4'h0, 32'h0, 0);
        issue(1'b1, 32'h7004_0000, 4'hF, 32'h1234_5678, 0);
        issue(1'b0, 32'h6FFF_FFFC, 4'h0, 32'h0, 0);
        issue(1'b0, 32'h7003_FFFC, 4'h0, 32'h0, 0);
        idle(4, 0);

        issue(1'b0, 32'h7000_0000, 4'h0, 32'h0, 0);
        issue(1'b0, 32'h7000_0004, 4'h0, 32'h0, 0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        rst_n   = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_state("midflight_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 0);
        issue(1'b0, 32'h7000_0004, 4'h0, 32'h0, 0);
        idle(4, 0);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            if (r < 80)
                a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (r < 88)
                a = BASE + 32'h0004_0000 + 32'(4 * $urandom_range(0, 255));
            else if (r < 92)
                a = BASE - 32'(4 * $urandom_range(1, 4));
            else
                a = BASE + 32'h0003_FFF0 + 32'(4 * $urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                  ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0);
            if ($urandom_range(0, 9) == 0)
                idle(int'($urandom_range(1, 3)), 1);
        end
        idle(5, 0);
        check("drain", 32'(sb.size()), 32'd0);

        lim_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
